// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one Hyperbus native memory port between NUM_REQ requesters.
// One requester owns the bus per transaction; an optional watchdog forces long grants off.
module hyperbus_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int TIMEOUT         = 0
) (
    input  logic                                 hbus_clk,
    input  logic                                 hbus_rst,
    input  logic [NUM_REQ-1:0]                   req_rrq,
    input  logic [NUM_REQ-1:0]                   req_wrq,
    input  logic [NUM_REQ*HBUS_ADDR_WIDTH-1:0]   req_adr,
    input  logic [NUM_REQ*HBUS_DATA_WIDTH-1:0]   req_dat,
    output logic [NUM_REQ-1:0]                   req_gnt,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   req_valid,
    output logic [HBUS_DATA_WIDTH-1:0]           req_dat_o,
    output logic                                 timeout,
    output logic                                 proto_err,
    output logic [HBUS_ADDR_WIDTH-1:0]           hbus_adr_o,
    output logic [HBUS_DATA_WIDTH-1:0]           hbus_dat_o,
    output logic                                 hbus_rrq,
    output logic                                 hbus_wrq,
    input  logic [HBUS_DATA_WIDTH-1:0]           hbus_dat_i,
    input  logic                                 hbus_ready,
    input  logic                                 hbus_valid,
    input  logic                                 hbus_busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        GRANT   = 3'b010,
        RELEASE = 3'b100
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        last_q, last_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ-1:0]   req_any;
    logic [IW-1:0]        pick;
    logic [IW-1:0]        cand_idx;
    logic                 found;
    int                   cand;

    assign req_any   = req_rrq | req_wrq;
    assign req_gnt   = gnt_q;
    assign timeout   = timeout_q;
    assign req_dat_o = hbus_dat_i;

    // Search starts just after the last owner, so it always ends up lowest priority.
    always_comb begin
        pick     = last_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IW'(cand);
            if (!found && req_any[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
    end

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_any && !hbus_busy) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    idx_d       = pick;
                    timer_d     = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (!req_any[idx_q]) begin
                    gnt_d   = '0;
                    last_d  = idx_q;
                    state_d = RELEASE;
                end else if (TIMEOUT != 0 && timer_q == TLAST) begin
                    gnt_d     = '0;
                    last_d    = idx_q;
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RELEASE: begin
                // Controller must finish before the next owner; this also forces a dead cycle.
                if (!hbus_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hbus_adr_o = '0;
        hbus_dat_o = '0;
        hbus_rrq   = 1'b0;
        hbus_wrq   = 1'b0;
        req_ready  = '0;
        req_valid  = '0;
        proto_err  = 1'b0;
        if (state_q == GRANT) begin
            hbus_adr_o       = req_adr[int'(idx_q)*HBUS_ADDR_WIDTH +: HBUS_ADDR_WIDTH];
            hbus_dat_o       = req_dat[int'(idx_q)*HBUS_DATA_WIDTH +: HBUS_DATA_WIDTH];
            hbus_rrq         = req_rrq[idx_q];
            hbus_wrq         = req_wrq[idx_q] & ~req_rrq[idx_q];
            req_ready[idx_q] = hbus_ready;
            req_valid[idx_q] = hbus_valid;
            proto_err        = req_rrq[idx_q] & req_wrq[idx_q];
        end
    end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Bench for hyperbus_arbiter: expected grant order is queued as requests are driven
// and checked whenever a new grant appears; directed checks cover routing and timing.
module tb_hyperbus_arbiter;

    logic        hbus_clk = 1'b0;
    logic        hbus_rst;
    logic [1:0]  req_rrq, req_wrq;
    logic [63:0] req_adr;
    logic [31:0] req_dat;
    logic [1:0]  req_gnt, req_ready, req_valid;
    logic [15:0] req_dat_o;
    logic        timeout, proto_err;
    logic [31:0] hbus_adr_o;
    logic [15:0] hbus_dat_o;
    logic        hbus_rrq, hbus_wrq;
    logic [15:0] hbus_dat_i;
    logic        hbus_ready, hbus_valid, hbus_busy;

    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_q[$];
    logic [1:0]  prev_gnt = 2'b00;
    logic [1:0]  exp_gnt;
    int          exp_idx;

    hyperbus_arbiter #(
        .NUM_REQ(2), .HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16), .TIMEOUT(8)
    ) dut (
        .hbus_clk(hbus_clk), .hbus_rst(hbus_rst),
        .req_rrq(req_rrq), .req_wrq(req_wrq), .req_adr(req_adr), .req_dat(req_dat),
        .req_gnt(req_gnt), .req_ready(req_ready), .req_valid(req_valid),
        .req_dat_o(req_dat_o), .timeout(timeout), .proto_err(proto_err),
        .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_dat_i(hbus_dat_i),
        .hbus_ready(hbus_ready), .hbus_valid(hbus_valid), .hbus_busy(hbus_busy)
    );

    always #5 hbus_clk = ~hbus_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hbus_clk);
        #1;
    endtask

    // Every rising grant must match the next queued owner.
    always @(negedge hbus_clk) begin
        if (req_gnt != 2'b00 && prev_gnt == 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_gnt", {62'd0, req_gnt}, 64'd0);
            end else begin
                exp_idx = exp_q.pop_front();
                exp_gnt = 2'b00;
                exp_gnt[exp_idx] = 1'b1;
                chk("sb_gnt", {62'd0, req_gnt}, {62'd0, exp_gnt});
            end
        end
        prev_gnt = req_gnt;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        hbus_rst = 1'b1;
        req_rrq = '0; req_wrq = '0; req_adr = '0; req_dat = '0;
        hbus_dat_i = 16'h5A5A; hbus_ready = 1'b0; hbus_valid = 1'b0; hbus_busy = 1'b0;
        #1;
        chk("rst_gnt", {62'd0, req_gnt}, 64'd0);
        chk("rst_rrq", {63'd0, hbus_rrq}, 64'd0);
        chk("rst_adr", {32'd0, hbus_adr_o}, 64'd0);
        chk("rst_timeout", {63'd0, timeout}, 64'd0);
        chk("rst_proto", {63'd0, proto_err}, 64'd0);
        chk("dat_bcast", {48'd0, req_dat_o}, 64'h5A5A);
        tick(); tick();
        hbus_rst = 1'b0;
        tick();

        // Single read from requester 0
        req_rrq = 2'b01; req_adr[31:0] = 32'h100; exp_q.push_back(0);
        tick();
        chk("rd_gnt", {62'd0, req_gnt}, 64'h1);
        chk("rd_rrq", {63'd0, hbus_rrq}, 64'h1);
        chk("rd_adr", {32'd0, hbus_adr_o}, 64'h100);
        hbus_valid = 1'b1; #1;
        chk("rd_valid1", {62'd0, req_valid}, 64'h1);
        hbus_valid = 1'b0; #1;
        chk("rd_valid_lo", {62'd0, req_valid}, 64'h0);
        tick();
        hbus_valid = 1'b1; #1;
        chk("rd_valid2", {62'd0, req_valid}, 64'h1);
        hbus_valid = 1'b0;
        req_rrq = 2'b00; #1;
        chk("rd_drop_rrq", {63'd0, hbus_rrq}, 64'h0);
        tick();
        chk("rd_drop_gnt", {62'd0, req_gnt}, 64'h0);
        tick(); tick();

        // Contention straight out of reset
        hbus_rst = 1'b1; tick(); hbus_rst = 1'b0;
        req_rrq = 2'b11; exp_q.push_back(0); exp_q.push_back(1);
        tick();
        chk("ct_first", {62'd0, req_gnt}, 64'h1);
        tick();
        req_rrq = 2'b10;
        tick();
        chk("ct_rel", {62'd0, req_gnt}, 64'h0);
        tick();
        chk("ct_dead", {62'd0, req_gnt}, 64'h0);
        tick();
        chk("ct_second", {62'd0, req_gnt}, 64'h2);
        req_rrq = 2'b00;
        tick(); tick(); tick();
        req_rrq = 2'b11; exp_q.push_back(0);
        tick();
        chk("ct_again", {62'd0, req_gnt}, 64'h1);
        req_rrq = 2'b01;           // pending requester 1 gives up
        tick();
        req_rrq = 2'b00;
        tick(); tick(); tick();
        chk("ct_no_pending", {62'd0, req_gnt}, 64'h0);

        // Busy hold-off then write routing from requester 1
        hbus_busy = 1'b1;
        req_wrq = 2'b10; req_adr[63:32] = 32'h20; req_dat[31:16] = 16'hBEEF;
        exp_q.push_back(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_hold", {62'd0, req_gnt}, 64'h0);
        end
        hbus_busy = 1'b0;
        tick();
        chk("wr_gnt", {62'd0, req_gnt}, 64'h2);
        chk("wr_wrq", {63'd0, hbus_wrq}, 64'h1);
        chk("wr_rrq", {63'd0, hbus_rrq}, 64'h0);
        chk("wr_dat", {48'd0, hbus_dat_o}, 64'hBEEF);
        chk("wr_adr", {32'd0, hbus_adr_o}, 64'h20);
        hbus_ready = 1'b1; #1;
        chk("wr_ready", {62'd0, req_ready}, 64'h2);
        hbus_ready = 1'b0;
        tick();
        req_wrq = 2'b00;
        tick(); tick(); tick();

        // Watchdog: requester 0 hogs the bus
        req_rrq = 2'b11; exp_q.push_back(0); exp_q.push_back(1);
        tick();
        n = 0;
        while (req_gnt == 2'b01 && n < 20) begin
            n++;
            tick();
        end
        chk("to_len", 64'(n), 64'd8);
        chk("to_pulse", {63'd0, timeout}, 64'h1);
        chk("to_rel", {62'd0, req_gnt}, 64'h0);
        tick();
        chk("to_pulse_end", {63'd0, timeout}, 64'h0);
        tick();
        chk("to_next", {62'd0, req_gnt}, 64'h2);
        req_rrq = 2'b01; exp_q.push_back(0);
        tick(); tick(); tick();
        chk("to_regrant", {62'd0, req_gnt}, 64'h1);
        req_rrq = 2'b00;
        tick(); tick(); tick();

        // Read and write together, then reset while granted
        req_rrq = 2'b01; req_wrq = 2'b01; exp_q.push_back(0);
        tick();
        chk("pe_rrq", {63'd0, hbus_rrq}, 64'h1);
        chk("pe_wrq", {63'd0, hbus_wrq}, 64'h0);
        chk("pe_pulse", {63'd0, proto_err}, 64'h1);
        tick();
        chk("pe_pulse2", {63'd0, proto_err}, 64'h1);
        hbus_rst = 1'b1; #1;
        chk("arst_gnt", {62'd0, req_gnt}, 64'h0);
        chk("arst_rrq", {63'd0, hbus_rrq}, 64'h0);
        chk("arst_pe", {63'd0, proto_err}, 64'h0);
        req_rrq = 2'b00; req_wrq = 2'b00;
        tick();
        hbus_rst = 1'b0;
        tick(); tick();

        chk("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbus_arbiter.md
Name: hyperbus_arbiter

Overview:
- Round-robin arbiter in the hbus_clk domain. Shares one Hyperbus native memory interface between NUM_REQ requesters, for example several FIFO bridges or a DMA engine.
- Grants the bus to one requester per transaction and muxes address, write data and rrq/wrq to the controller.
- Routes ready/valid back to the granted requester only.
- Supports an optional grant-timeout watchdog.

Parameters:
- NUM_REQ, 2: number of requester ports (2..8).
- HBUS_ADDR_WIDTH, 32: address width.
- HBUS_DATA_WIDTH, 16: data word width.
- TIMEOUT, 0: maximum grant length in hbus_clk cycles. 0 disables the watchdog.

Ports:
- hbus_clk  in  1  controller clock
- hbus_rst  in  1  reset
- req_rrq  in  NUM_REQ  per-requester read request; held for the whole transaction
- req_wrq  in  NUM_REQ  per-requester write request; held for the whole transaction
- req_adr  in  NUM_REQ*HBUS_ADDR_WIDTH  packed addresses; requester i at [i*AW +: AW]
- req_dat  in  NUM_REQ*HBUS_DATA_WIDTH  packed write data
- req_gnt  out  NUM_REQ  one-hot grant, registered
- req_ready  out  NUM_REQ  hbus_ready routed to the granted requester
- req_valid  out  NUM_REQ  hbus_valid routed to the granted requester
- req_dat_o  out  HBUS_DATA_WIDTH  hbus_dat_i broadcast to all requesters
- timeout  out  1  one-cycle pulse on a forced release
- proto_err  out  1  one-cycle pulse when the granted requester asserts rrq and wrq together
- hbus_adr_o  out  HBUS_ADDR_WIDTH  address to controller
- hbus_dat_o  out  HBUS_DATA_WIDTH  write data to controller
- hbus_rrq  out  1  read request to controller
- hbus_wrq  out  1  write request to controller
- hbus_dat_i  in  HBUS_DATA_WIDTH  read data from controller
- hbus_ready  in  1  controller accepted a write word
- hbus_valid  in  1  controller presents a read word
- hbus_busy  in  1  controller transaction in progress

Behaviour:
- Clock is hbus_clk. Reset is hbus_rst, asynchronous, active-high.
- Reset state:
  - state=IDLE, req_gnt=0, timeout=0, proto_err=0, timer=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
  - All hbus_* outputs are 0 (combinationally, because nothing is granted).
- Reset mid-transaction drops the grant immediately. Requesters and controller are reset by the same reset.
- Request vector: req_any[i] = req_rrq[i] | req_wrq[i].
- States: IDLE, GRANT, RELEASE (one-hot).
- IDLE:
  - If |req_any and !hbus_busy: select the first i with req_any[i] set, searching (last+1) mod N upward with wrap.
  - Set req_gnt <= onehot(i), idx <= i, timer <= 0, go to GRANT.
  - Otherwise stay in IDLE.
  - Latency: a request seen at edge n gives req_gnt and hbus_rrq/wrq high after edge n+1.
- GRANT (combinational mux, outputs drive only in this state):
  - hbus_adr_o = req_adr[idx], hbus_dat_o = req_dat[idx].
  - hbus_rrq = req_rrq[idx].
  - hbus_wrq = req_wrq[idx] & ~req_rrq[idx]: read wins when both are set, and proto_err pulses on every such cycle.
  - req_ready[idx] = hbus_ready and req_valid[idx] = hbus_valid; all other bits are 0.
- Outside GRANT:
  - All hbus_* request, address and data outputs are 0.
  - All req_ready and req_valid bits are 0.
- GRANT exits:
  - When !req_any[idx]: req_gnt <= 0, last <= idx, go to RELEASE.
  - When TIMEOUT!=0 and timer==TIMEOUT-1 with the request still held: same as above, plus timeout pulses for one cycle.
  - Otherwise timer increments, saturating.
- RELEASE: wait for !hbus_busy, then go to IDLE. This guarantees at least one dead cycle between transactions.
- Non-granted requests are held pending with no side effects. Requests dropping while pending are simply not granted.
- A force-released requester still asserting its request competes again at lowest priority. If it is the only requester it is re-granted.

Test Plan:
- Single read: req_rrq[0]=1 with adr 0x100, hbus_busy=0 at edge 0 -> req_gnt=01 and hbus_rrq=1 with hbus_adr_o=0x100 after edge 1. Two hbus_valid pulses -> req_valid[0] pulses twice, req_valid[1]=0. Drop rrq -> gnt=0 on the next edge and hbus_rrq=0 the same cycle.
- Contention: both requesters raise requests in the same cycle from reset -> requester 0 granted first, requester 1 granted after 0 releases, with ≥1 idle cycle between grants. A repeated simultaneous request afterwards -> requester 0 granted (pointer last=1, so the search starts at 0).
- Busy hold-off: requester 1 requests while hbus_busy=1 for 5 cycles -> no grant during those cycles. Grant appears after the edge following busy falling.
- Write routing: requester 1 writes 0xBEEF to adr 0x20 -> hbus_wrq=1, hbus_dat_o=0xBEEF, hbus_ready is routed only to req_ready[1].
- Timeout: TIMEOUT=8, requester 0 holds rrq forever while requester 1 requests -> timeout pulses, gnt0 drops after 8 granted cycles, and requester 1 is granted next.
- Protocol error and reset: requester 0 asserts rrq and wrq together -> hbus_rrq=1, hbus_wrq=0, proto_err pulses. Asserting hbus_rst mid-grant -> req_gnt=0 and hbus_rrq=0 immediately, without waiting for a clock edge.
